egress_mac_stamp_nmu: RTL and testbench
=======================================

Name: egress_mac_stamp_nmu

Overview:
Egress-side Network Management Unit, the TX counterpart of the RX tdest-from-destination-MAC router. Sits between the AXI-Stream TX arbiter (tid identifies the originating virtual port) and the shared network interface. Per packet it validates the sender ID, drops packets from disallowed IDs, and overwrites the low bits of the source MAC LSB byte (frame byte 11) with the sender ID. This keeps the source MAC consistent with the RX routing rule (destination MAC LSBs select tdest).

Parameters:
AXIS_BUS_WIDTH, 64, stream data width in bits; multiple of 8; minimum 8.
AXIS_ID_WIDTH, 4, tid width; 1..8.
NUM_VIFS, 16, number of valid sender IDs; a packet is accepted only if its first-beat tid < NUM_VIFS; 1..2^AXIS_ID_WIDTH.
CNT_WIDTH, 16, width of the saturating drop counter.

Ports:
aclk  in  1  clock; all signals synchronous to its rising edge.
areset  in  1  asynchronous, active-high reset.
axis_tx_s_tdata  in  AXIS_BUS_WIDTH  egress input data.
axis_tx_s_tkeep  in  AXIS_BUS_WIDTH/8  byte enables.
axis_tx_s_tid  in  AXIS_ID_WIDTH  sender virtual-port ID.
axis_tx_s_tlast  in  1  end of packet.
axis_tx_s_tvalid  in  1  input valid.
axis_tx_s_tready  out  1  input ready.
axis_tx_m_tdata  out  AXIS_BUS_WIDTH  stamped output data.
axis_tx_m_tkeep  out  AXIS_BUS_WIDTH/8  byte enables (pass-through).
axis_tx_m_tlast  out  1  end of packet.
axis_tx_m_tvalid  out  1  output valid.
axis_tx_m_tready  in  1  output ready.
err_tid_change  out  1  one-cycle pulse: tid changed mid-packet.
err_drop  out  1  one-cycle pulse: packet dropped (asserted on its first beat).
drop_count  out  CNT_WIDTH  saturating count of dropped packets.

Behaviour:
- Constants: BPB = AXIS_BUS_WIDTH/8; STAMP_BEAT = 11 / BPB; STAMP_LANE = 11 % BPB.
- Output path: one register stage; latency is 1 cycle from input accept to output valid.
- Throughput: full rate. axis_tx_s_tready = DROP state OR !m_tvalid OR axis_tx_m_tready. This is combinational from m_tready.
- Output hold: registered output fields hold stable while m_tvalid=1 and m_tready=0.
- Beat accept condition: s_tvalid && s_tready.
- FSM states: FIRST, BODY, DROP. Reset state is FIRST.
- FIRST, accepted beat with tid < NUM_VIFS:
  - latch tid into cur_id;
  - forward the beat;
  - stay in FIRST if tlast, otherwise go to BODY.
- FIRST, accepted beat with tid >= NUM_VIFS:
  - do not forward the beat;
  - pulse err_drop;
  - increment drop_count, saturating at all-ones;
  - stay in FIRST if tlast, otherwise go to DROP.
- BODY, accepted beat:
  - forward the beat;
  - if tid != cur_id, pulse err_tid_change (one pulse per offending beat);
  - go to FIRST on tlast.
- DROP, accepted beat:
  - discard the beat; tready=1 regardless of output state;
  - go to FIRST on tlast.
- Beat counter:
  - reset to 0 on each packet's first beat;
  - increments per accepted beat;
  - saturates at STAMP_BEAT+1;
  - width $clog2(STAMP_BEAT+2).
- Stamping:
  - applies only on the forwarded beat where beat index == STAMP_BEAT and tkeep[STAMP_LANE]=1;
  - tdata[STAMP_LANE*8 +: AXIS_ID_WIDTH] is replaced with the ID: the first-beat tid if STAMP_BEAT==0, otherwise cur_id;
  - all other bits are unchanged.
- Runt packets: if tlast occurs before STAMP_BEAT, or the lane's keep bit is clear, the packet is forwarded unmodified with no error.
- Reset values: m_tvalid=0, m_tdata/tkeep/tlast=0, err pulses 0, drop_count=0, cur_id=0, state FIRST.
- Reset mid-packet: an in-flight output beat is discarded (m_tvalid=0). The first beat after reset is treated as a packet start.

Decomposition:
- Package egress_nmu_pkg: FSM state enum (FIRST/BODY/DROP) and functions computing STAMP_BEAT and STAMP_LANE from the bus width.
- One sub-module: axis_reg_slice (single-stage AXI-Stream pipeline register: data/keep/last, valid/ready).
- FSM, counter and stamp mux stay in the top module.

Test Plan:
- W=64, NUM_VIFS=16: tid=3, 2-beat frame, byte 11 = 0xA0. Expect output byte 11 = 0xA3, every other byte identical, m_tvalid 1 cycle after accept.
- NUM_VIFS=8: 3-beat packet with tid=9, then 2-beat packet with tid=2. Expect no output for the first packet, err_drop pulse once, drop_count=1, second packet forwarded and stamped with 2.
- Back-to-back 64-beat packets, random tids <16, 50% random m_tready. Expect every beat delivered exactly once, in order, stamped correctly, and s_tready never asserted while the output is held.
- tid=3 on beat 0, tid=5 on beat 1. Expect err_tid_change pulses once and byte 11 low nibble = 3.
- 1-beat runt (tlast on beat 0) with tid=4, then a normal 2-beat packet with tid=6. Expect runt unmodified with no error, second packet's byte 11 low nibble = 6.
- Assert areset mid-packet while m_tvalid=1 and m_tready=0. Expect m_tvalid=0 immediately, drop_count=0, next packet stamped as a fresh packet.
- Repeat the first scenario at W=8 (stamp on beat 11, lane 0) and W=512 (stamp on beat 0, lane 11).

Source files
------------

// File: rtl/egress_nmu_pkg.sv
// egress_nmu_pkg
//   Shared definitions for the egress MAC-stamping NMU: the packet FSM state
//   encoding and helpers that locate frame byte 11 (source MAC LSB) on a
//   stream of a given bus width.
package egress_nmu_pkg;

    typedef enum logic [1:0] {
        ST_FIRST = 2'd0,    // waiting for / on the first beat of a packet
        ST_BODY  = 2'd1,    // forwarding the rest of an accepted packet
        ST_DROP  = 2'd2     // discarding the rest of a rejected packet
    } nmu_state_e;

    // Beat index that carries frame byte 11.
    function automatic int stamp_beat(input int bus_w);
        return 11 / (bus_w / 8);
    endfunction

    // Byte lane within that beat that carries frame byte 11.
    function automatic int stamp_lane(input int bus_w);
        return 11 % (bus_w / 8);
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// axis_reg_slice
//   Single-stage AXI-Stream pipeline register (data/keep/last). Full
//   throughput: accepts a new beat whenever the register is empty or being
//   drained in the same cycle. Output fields hold while valid && !ready.
// Ports:
//   aclk, areset         clock, async active-high reset
//   i_s_t*, o_s_tready   upstream side
//   o_m_t*, i_m_tready   downstream side
module axis_reg_slice #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [DATA_W-1:0] i_s_tdata,
    input  logic [KEEP_W-1:0] i_s_tkeep,
    input  logic              i_s_tlast,
    input  logic              i_s_tvalid,
    output logic              o_s_tready,
    output logic [DATA_W-1:0] o_m_tdata,
    output logic [KEEP_W-1:0] o_m_tkeep,
    output logic              o_m_tlast,
    output logic              o_m_tvalid,
    input  logic              i_m_tready
);

    logic [DATA_W-1:0] r_data;
    logic [KEEP_W-1:0] r_keep;
    logic              r_last;
    logic              r_valid;

    assign o_s_tready = !r_valid || i_m_tready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            if (o_s_tready) r_valid <= i_s_tvalid;
            if (i_s_tvalid && o_s_tready) begin
                r_data <= i_s_tdata;
                r_keep <= i_s_tkeep;
                r_last <= i_s_tlast;
            end
        end
    end

    assign o_m_tdata  = r_data;
    assign o_m_tkeep  = r_keep;
    assign o_m_tlast  = r_last;
    assign o_m_tvalid = r_valid;

endmodule

// File: rtl/egress_mac_stamp_nmu.sv
// egress_mac_stamp_nmu
//   Egress NMU between the TX arbiter and the shared network interface.
//   Per packet: validates the first-beat tid against NUM_VIFS, drops packets
//   from invalid senders (counting them), and overwrites the low ID bits of
//   frame byte 11 (source MAC LSB) with the sender ID so the source MAC
//   matches the RX routing rule.
// Ports:
//   aclk, areset                 clock, async active-high reset
//   axis_tx_s_*                  egress input stream (tid = sender ID)
//   axis_tx_m_*                  stamped output stream, 1-cycle latency
//   err_tid_change, err_drop     single-cycle error pulses
//   drop_count                   saturating dropped-packet count
module egress_mac_stamp_nmu
    import egress_nmu_pkg::*;
#(
    parameter int AXIS_BUS_WIDTH = 64,
    parameter int AXIS_ID_WIDTH  = 4,
    parameter int NUM_VIFS       = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [AXIS_BUS_WIDTH-1:0]   axis_tx_s_tdata,
    input  logic [AXIS_BUS_WIDTH/8-1:0] axis_tx_s_tkeep,
    input  logic [AXIS_ID_WIDTH-1:0]    axis_tx_s_tid,
    input  logic                        axis_tx_s_tlast,
    input  logic                        axis_tx_s_tvalid,
    output logic                        axis_tx_s_tready,
    output logic [AXIS_BUS_WIDTH-1:0]   axis_tx_m_tdata,
    output logic [AXIS_BUS_WIDTH/8-1:0] axis_tx_m_tkeep,
    output logic                        axis_tx_m_tlast,
    output logic                        axis_tx_m_tvalid,
    input  logic                        axis_tx_m_tready,
    output logic                        err_tid_change,
    output logic                        err_drop,
    output logic [CNT_WIDTH-1:0]        drop_count
);

    localparam int STAMP_BEAT = stamp_beat(AXIS_BUS_WIDTH);
    localparam int STAMP_LANE = stamp_lane(AXIS_BUS_WIDTH);
    localparam int BCW        = $clog2(STAMP_BEAT + 2);
    localparam logic [BCW-1:0] BEAT_STAMP = BCW'(STAMP_BEAT);
    localparam logic [BCW-1:0] BEAT_SAT   = BCW'(STAMP_BEAT + 1);
    // One extra bit so NUM_VIFS == 2**AXIS_ID_WIDTH is representable.
    localparam logic [AXIS_ID_WIDTH:0] NV = (AXIS_ID_WIDTH + 1)'(NUM_VIFS);

    nmu_state_e                 r_state, w_state_nxt;
    logic [AXIS_ID_WIDTH-1:0]   r_cur_id;
    logic [BCW-1:0]             r_beat;
    logic [CNT_WIDTH-1:0]       r_drop_cnt;
    logic                       r_err_tid, r_err_drop;

    logic                       w_slice_rdy;
    logic                       w_s_tready;
    logic                       w_fwd;
    logic                       w_acc;
    logic                       w_first;
    logic                       w_tid_ok;
    logic [BCW-1:0]             w_idx;
    logic [AXIS_ID_WIDTH-1:0]   w_id;
    logic [AXIS_BUS_WIDTH-1:0]  w_tdata;

    assign w_first  = (r_state == ST_FIRST);
    assign w_tid_ok = ({1'b0, axis_tx_s_tid} < NV);
    assign w_acc    = axis_tx_s_tvalid && w_s_tready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= ST_FIRST;
        else        r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_acc) begin
            case (r_state)
                ST_FIRST: if (!axis_tx_s_tlast) w_state_nxt = w_tid_ok ? ST_BODY : ST_DROP;
                ST_BODY,
                ST_DROP:  if (axis_tx_s_tlast)  w_state_nxt = ST_FIRST;
                default:  w_state_nxt = ST_FIRST;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // DROP swallows beats without touching the output register, so it is
    // ready even while the output is stalled.
    always_comb begin
        w_s_tready = w_slice_rdy;
        w_fwd      = 1'b0;
        case (r_state)
            ST_FIRST: w_fwd = w_tid_ok;
            ST_BODY:  w_fwd = 1'b1;
            ST_DROP:  w_s_tready = 1'b1;
            default:  w_fwd = 1'b0;
        endcase
    end

    assign axis_tx_s_tready = w_s_tready;

    // ---------------- Beat counter, ID latch, errors ----------------
    // r_beat counts beats already accepted in the current packet; the
    // current beat's index is 0 in FIRST, r_beat otherwise.
    // Error pulses are registered so they line up with the output stage.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_cur_id   <= '0;
            r_beat     <= '0;
            r_drop_cnt <= '0;
            r_err_tid  <= 1'b0;
            r_err_drop <= 1'b0;
        end else begin
            r_err_tid  <= w_acc && (r_state == ST_BODY) && (axis_tx_s_tid != r_cur_id);
            r_err_drop <= w_acc && w_first && !w_tid_ok;
            if (w_acc) begin
                if (w_first) begin
                    r_beat <= BCW'(1);
                    if (w_tid_ok) r_cur_id <= axis_tx_s_tid;
                end else if (r_beat != BEAT_SAT) begin
                    r_beat <= r_beat + 1'b1;
                end
            end
            if (w_acc && w_first && !w_tid_ok && (r_drop_cnt != '1))
                r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    // ---------------- Stamp mux ----------------
    // On the first beat the live tid is the packet ID (covers STAMP_BEAT==0).
    assign w_idx = w_first ? '0 : r_beat;
    assign w_id  = w_first ? axis_tx_s_tid : r_cur_id;

    always_comb begin
        w_tdata = axis_tx_s_tdata;
        if ((w_idx == BEAT_STAMP) && axis_tx_s_tkeep[STAMP_LANE])
            w_tdata[STAMP_LANE*8 +: AXIS_ID_WIDTH] = w_id;
    end

    axis_reg_slice #(
        .DATA_W (AXIS_BUS_WIDTH),
        .KEEP_W (AXIS_BUS_WIDTH / 8)
    ) u_slice (
        .aclk       (aclk),
        .areset     (areset),
        .i_s_tdata  (w_tdata),
        .i_s_tkeep  (axis_tx_s_tkeep),
        .i_s_tlast  (axis_tx_s_tlast),
        .i_s_tvalid (axis_tx_s_tvalid && w_fwd),
        .o_s_tready (w_slice_rdy),
        .o_m_tdata  (axis_tx_m_tdata),
        .o_m_tkeep  (axis_tx_m_tkeep),
        .o_m_tlast  (axis_tx_m_tlast),
        .o_m_tvalid (axis_tx_m_tvalid),
        .i_m_tready (axis_tx_m_tready)
    );

    assign err_tid_change = r_err_tid;
    assign err_drop       = r_err_drop;
    assign drop_count     = r_drop_cnt;

endmodule

// File: tb/tb_egress_mac_stamp_nmu.sv
// Bench for egress_mac_stamp_nmu. Four instances:
//   a: 64-bit, NUM_VIFS=16 (table vectors, random backpressure, reset)
//   b: 64-bit, NUM_VIFS=8  (drop path)
//   c: 8-bit  (stamp on beat 11, lane 0)
//   w: 512-bit (stamp on beat 0, lane 11)
// Expected beats are queued per instance when a beat is accepted and popped
// when that instance presents an output beat.
module tb_egress_mac_stamp_nmu;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
    } beat_t;

    typedef struct {
        logic [3:0]  tid0;
        logic [3:0]  tid1;
        logic        one;
        logic [63:0] d0;
        logic [63:0] e0;
        logic [63:0] d1;
        logic [7:0]  k1;
        logic [63:0] e1;
        int          ntid;
    } vec_t;

    logic aclk   = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;
    beat_t q[4][$];
    vec_t  vt[6];

    // instance a
    logic [63:0] a_d, a_md;
    logic [7:0]  a_k, a_mk;
    logic [3:0]  a_id;
    logic        a_l, a_v, a_sr, a_ml, a_mv, a_mr, a_et, a_ed;
    logic [15:0] a_cnt;
    // instance b
    logic [63:0] b_d, b_md;
    logic [7:0]  b_k, b_mk;
    logic [3:0]  b_id;
    logic        b_l, b_v, b_sr, b_ml, b_mv, b_et, b_ed;
    logic [15:0] b_cnt;
    // instance c
    logic [7:0]  c_d, c_md;
    logic [0:0]  c_k, c_mk;
    logic [3:0]  c_id;
    logic        c_l, c_v, c_sr, c_ml, c_mv, c_et, c_ed;
    logic [15:0] c_cnt;
    // instance w
    logic [511:0] w_d, w_md;
    logic [63:0]  w_k, w_mk;
    logic [3:0]   w_id;
    logic         w_l, w_v, w_sr, w_ml, w_mv, w_et, w_ed;
    logic [15:0]  w_cnt;

    egress_mac_stamp_nmu #(.AXIS_BUS_WIDTH(64), .AXIS_ID_WIDTH(4), .NUM_VIFS(16), .CNT_WIDTH(16)) dut_a (
        .aclk(aclk), .areset(areset),
        .axis_tx_s_tdata(a_d), .axis_tx_s_tkeep(a_k), .axis_tx_s_tid(a_id), .axis_tx_s_tlast(a_l),
        .axis_tx_s_tvalid(a_v), .axis_tx_s_tready(a_sr),
        .axis_tx_m_tdata(a_md), .axis_tx_m_tkeep(a_mk), .axis_tx_m_tlast(a_ml),
        .axis_tx_m_tvalid(a_mv), .axis_tx_m_tready(a_mr),
        .err_tid_change(a_et), .err_drop(a_ed), .drop_count(a_cnt));

    egress_mac_stamp_nmu #(.AXIS_BUS_WIDTH(64), .AXIS_ID_WIDTH(4), .NUM_VIFS(8), .CNT_WIDTH(16)) dut_b (
        .aclk(aclk), .areset(areset),
        .axis_tx_s_tdata(b_d), .axis_tx_s_tkeep(b_k), .axis_tx_s_tid(b_id), .axis_tx_s_tlast(b_l),
        .axis_tx_s_tvalid(b_v), .axis_tx_s_tready(b_sr),
        .axis_tx_m_tdata(b_md), .axis_tx_m_tkeep(b_mk), .axis_tx_m_tlast(b_ml),
        .axis_tx_m_tvalid(b_mv), .axis_tx_m_tready(1'b1),
        .err_tid_change(b_et), .err_drop(b_ed), .drop_count(b_cnt));

    egress_mac_stamp_nmu #(.AXIS_BUS_WIDTH(8), .AXIS_ID_WIDTH(4), .NUM_VIFS(16), .CNT_WIDTH(16)) dut_c (
        .aclk(aclk), .areset(areset),
        .axis_tx_s_tdata(c_d), .axis_tx_s_tkeep(c_k), .axis_tx_s_tid(c_id), .axis_tx_s_tlast(c_l),
        .axis_tx_s_tvalid(c_v), .axis_tx_s_tready(c_sr),
        .axis_tx_m_tdata(c_md), .axis_tx_m_tkeep(c_mk), .axis_tx_m_tlast(c_ml),
        .axis_tx_m_tvalid(c_mv), .axis_tx_m_tready(1'b1),
        .err_tid_change(c_et), .err_drop(c_ed), .drop_count(c_cnt));

    egress_mac_stamp_nmu #(.AXIS_BUS_WIDTH(512), .AXIS_ID_WIDTH(4), .NUM_VIFS(16), .CNT_WIDTH(16)) dut_w (
        .aclk(aclk), .areset(areset),
        .axis_tx_s_tdata(w_d), .axis_tx_s_tkeep(w_k), .axis_tx_s_tid(w_id), .axis_tx_s_tlast(w_l),
        .axis_tx_s_tvalid(w_v), .axis_tx_s_tready(w_sr),
        .axis_tx_m_tdata(w_md), .axis_tx_m_tkeep(w_mk), .axis_tx_m_tlast(w_ml),
        .axis_tx_m_tvalid(w_mv), .axis_tx_m_tready(1'b1),
        .err_tid_change(w_et), .err_drop(w_ed), .drop_count(w_cnt));

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic mon(input int s, input logic [511:0] d, input logic [63:0] k, input logic l);
        beat_t e;
        if (q[s].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat_dut%0d: got data %0h, required no beat", s, d);
        end else begin
            e = q[s].pop_front();
            chk($sformatf("dut%0d_data", s), d, e.d);
            chk($sformatf("dut%0d_keep", s), 512'(k), 512'(e.k));
            chk($sformatf("dut%0d_last", s), 512'(l), 512'(e.l));
        end
    endtask

    // Drive one beat on instance s, wait (bounded) for the handshake, and
    // queue the expected output beat when push is set.
    task automatic send(input int s, input logic [511:0] d, input logic [63:0] k,
                        input logic [3:0] id, input logic l, input logic push,
                        input logic [511:0] ed);
        int    n;
        logic  acc;
        beat_t e;
        n = 0;
        acc = 1'b0;
        case (s)
            0:       begin a_d = d[63:0]; a_k = k[7:0]; a_id = id; a_l = l; a_v = 1'b1; end
            1:       begin b_d = d[63:0]; b_k = k[7:0]; b_id = id; b_l = l; b_v = 1'b1; end
            2:       begin c_d = d[7:0];  c_k = k[0:0]; c_id = id; c_l = l; c_v = 1'b1; end
            default: begin w_d = d;       w_k = k;      w_id = id; w_l = l; w_v = 1'b1; end
        endcase
        while (!acc) begin
            @(negedge aclk);
            case (s)
                0:       acc = a_sr;
                1:       acc = b_sr;
                2:       acc = c_sr;
                default: acc = w_sr;
            endcase
            if (acc && push) begin
                e.d = ed;
                e.k = k;
                e.l = l;
                q[s].push_back(e);
            end
            @(posedge aclk);
            #1;
            n++;
            if (!acc && n >= 200) begin
                tests++;
                fails++;
                $display("FAIL send_timeout_dut%0d: tready low for %0d cycles, required high", s, n);
                acc = 1'b1;
            end
        end
        a_v = 1'b0;
        b_v = 1'b0;
        c_v = 1'b0;
        w_v = 1'b0;
    endtask

    task automatic drain(input int s);
        int n;
        n = 0;
        while (q[s].size() != 0 && n < 1000) begin
            @(posedge aclk);
            #1;
            n++;
        end
        repeat (2) @(posedge aclk);
        #1;
        chk($sformatf("drain_dut%0d", s), 512'(q[s].size()), 512'(0));
    endtask

    // Output monitors.
    always @(negedge aclk) begin
        if (!areset) begin
            if (a_mv && a_mr) mon(0, 512'(a_md), 64'(a_mk), a_ml);
            if (b_mv)         mon(1, 512'(b_md), 64'(b_mk), b_ml);
            if (c_mv)         mon(2, 512'(c_md), 64'(c_mk), c_ml);
            if (w_mv)         mon(3, w_md, w_mk, w_ml);
        end
    end

    // Pulse counters and output-hold checks on instance a.
    int a_ntid = 0, a_ndrop = 0, b_ntid = 0, b_ndrop = 0, cw_err = 0;
    int rdy_viol = 0, stab_viol = 0;
    logic        hold_prev = 1'b0;
    logic [63:0] hold_d;
    logic [7:0]  hold_k;
    logic        hold_l;
    always @(negedge aclk) begin
        if (a_et) a_ntid++;
        if (a_ed) a_ndrop++;
        if (b_et) b_ntid++;
        if (b_ed) b_ndrop++;
        if (c_et || c_ed || w_et || w_ed) cw_err++;
        if (!areset) begin
            if (hold_prev && (!a_mv || a_md !== hold_d || a_mk !== hold_k || a_ml !== hold_l))
                stab_viol++;
            if (a_mv && !a_mr && a_sr) rdy_viol++;
        end
        hold_prev = !areset && a_mv && !a_mr;
        hold_d = a_md;
        hold_k = a_mk;
        hold_l = a_ml;
    end

    // m_tready for instance a: forced level or 50% random.
    logic rnd_en  = 1'b0;
    logic a_force = 1'b1;
    initial begin
        a_mr = 1'b1;
        forever begin
            @(posedge aclk);
            #2;
            a_mr = rnd_en ? 1'($urandom_range(0, 1)) : a_force;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] d, ed;
        logic [63:0]  k;
        logic [3:0]   id;
        int           t0;

        vt[0] = '{tid0:4'd3, tid1:4'd3, one:1'b0, d0:64'h0011_2233_A044_5566, e0:64'h0011_2233_A044_5566,
                  d1:64'h0123_4567_A0AB_CDEF, k1:8'hFF, e1:64'h0123_4567_A3AB_CDEF, ntid:0};
        vt[1] = '{tid0:4'hF, tid1:4'hF, one:1'b0, d0:64'hFFFF_FFFF_FFFF_FFFF, e0:64'hFFFF_FFFF_FFFF_FFFF,
                  d1:64'h0, k1:8'hFF, e1:64'h0000_0000_0F00_0000, ntid:0};
        vt[2] = '{tid0:4'd5, tid1:4'd5, one:1'b0, d0:64'h0, e0:64'h0,
                  d1:64'h0123_4567_A0AB_CDEF, k1:8'hF7, e1:64'h0123_4567_A0AB_CDEF, ntid:0};
        vt[3] = '{tid0:4'd3, tid1:4'd5, one:1'b0, d0:64'h1234_5678_9ABC_DEF0, e0:64'h1234_5678_9ABC_DEF0,
                  d1:64'hFFFF_FFFF_FFFF_FFFF, k1:8'hFF, e1:64'hFFFF_FFFF_F3FF_FFFF, ntid:1};
        vt[4] = '{tid0:4'd4, tid1:4'd4, one:1'b1, d0:64'hDEAD_BEEF_A0A0_A0A0, e0:64'hDEAD_BEEF_A0A0_A0A0,
                  d1:64'h0, k1:8'hFF, e1:64'h0, ntid:0};
        vt[5] = '{tid0:4'd6, tid1:4'd6, one:1'b0, d0:64'h5555_5555_A055_5555, e0:64'h5555_5555_A055_5555,
                  d1:64'h0000_0000_A000_0000, k1:8'hFF, e1:64'h0000_0000_A600_0000, ntid:0};

        a_v = 1'b0; b_v = 1'b0; c_v = 1'b0; w_v = 1'b0;
        a_d = '0; a_k = '0; a_id = '0; a_l = 1'b0;
        b_d = '0; b_k = '0; b_id = '0; b_l = 1'b0;
        c_d = '0; c_k = '0; c_id = '0; c_l = 1'b0;
        w_d = '0; w_k = '0; w_id = '0; w_l = 1'b0;

        // Reset state.
        repeat (2) @(negedge aclk);
        chk("rst_a_mvalid", 512'(a_mv), 512'(1'b0));
        chk("rst_a_mdata",  512'(a_md), 512'(0));
        chk("rst_a_mlast",  512'(a_ml), 512'(1'b0));
        chk("rst_a_errs",   512'({a_et, a_ed}), 512'(0));
        chk("rst_a_cnt",    512'(a_cnt), 512'(0));
        chk("rst_b_mvalid", 512'(b_mv), 512'(1'b0));
        chk("rst_w_mvalid", 512'(w_mv), 512'(1'b0));
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(posedge aclk);
        #1;

        // Table vectors on instance a.
        for (int i = 0; i < 6; i++) begin
            t0 = a_ntid;
            send(0, 512'(vt[i].d0), 64'hFF, vt[i].tid0, vt[i].one, 1'b1, 512'(vt[i].e0));
            if (!vt[i].one)
                send(0, 512'(vt[i].d1), 64'(vt[i].k1), vt[i].tid1, 1'b1, 1'b1, 512'(vt[i].e1));
            repeat (3) @(posedge aclk);
            #1;
            chk($sformatf("vec%0d_tid_err", i), 512'(a_ntid - t0), 512'(vt[i].ntid));
        end
        drain(0);
        chk("vec_no_drop", 512'(a_ndrop), 512'(0));

        // Back-to-back 64-beat packets with random backpressure.
        t0 = a_ntid;
        rnd_en = 1'b1;
        for (int p = 0; p < 6; p++) begin
            id = 4'($urandom_range(0, 15));
            for (int b = 0; b < 64; b++) begin
                d = 512'({$urandom, $urandom});
                k = ($urandom_range(0, 3) == 0) ? 64'(8'($urandom)) : 64'hFF;
                ed = d;
                if (b == 1 && k[3]) ed[27:24] = id;
                send(0, d, k, id, (b == 63), 1'b1, ed);
            end
        end
        rnd_en = 1'b0;
        drain(0);
        chk("rand_ready_while_held", 512'(rdy_viol), 512'(0));
        chk("rand_hold_stable", 512'(stab_viol), 512'(0));
        chk("rand_tid_err", 512'(a_ntid - t0), 512'(0));

        // Drop path on instance b (NUM_VIFS=8).
        for (int b = 0; b < 3; b++)
            send(1, 512'(64'hAAAA_AAAA_A0AA_AAAA), 64'hFF, 4'd9, (b == 2), 1'b0, 512'(0));
        send(1, 512'(64'h1111_1111_A011_1111), 64'hFF, 4'd2, 1'b0, 1'b1, 512'(64'h1111_1111_A011_1111));
        send(1, 512'(64'h2222_2222_A022_2222), 64'hFF, 4'd2, 1'b1, 1'b1, 512'(64'h2222_2222_A222_2222));
        drain(1);
        chk("drop_pulses", 512'(b_ndrop), 512'(1));
        chk("drop_count_1", 512'(b_cnt), 512'(1));
        send(1, 512'(64'h3333_3333_A033_3333), 64'hFF, 4'd8, 1'b1, 1'b0, 512'(0));
        send(1, 512'(64'h4444_4444_A044_4444), 64'hFF, 4'd7, 1'b1, 1'b1, 512'(64'h4444_4444_A044_4444));
        drain(1);
        chk("drop_boundary_pulses", 512'(b_ndrop), 512'(2));
        chk("drop_count_2", 512'(b_cnt), 512'(2));
        chk("drop_tid_err", 512'(b_ntid), 512'(0));

        // 8-bit bus: stamp on beat 11, lane 0.
        for (int i = 0; i < 14; i++) begin
            d  = 512'((i == 11) ? 8'hA0 : 8'(i + 1));
            ed = 512'((i == 11) ? 8'hA3 : 8'(i + 1));
            send(2, d, 64'h1, 4'd3, (i == 13), 1'b1, ed);
        end
        drain(2);

        // 512-bit bus: stamp on beat 0, lane 11.
        for (int b = 0; b < 2; b++) begin
            for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
            d[95:88] = 8'hA0;
            ed = d;
            if (b == 0) ed[91:88] = 4'h3;
            send(3, d, 64'hFFFF_FFFF_FFFF_FFFF, 4'd3, (b == 1), 1'b1, ed);
        end
        drain(3);
        chk("cw_no_errors", 512'(cw_err), 512'(0));

        // Reset mid-packet while the output is held.
        a_force = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        send(0, 512'(64'h7777_7777_A077_7777), 64'hFF, 4'd2, 1'b0, 1'b0, 512'(0));
        chk("latency_mvalid", 512'(a_mv), 512'(1'b1));
        chk("latency_mdata", 512'(a_md), 512'(64'h7777_7777_A077_7777));
        @(posedge aclk);
        #1;
        chk("held_mvalid", 512'(a_mv), 512'(1'b1));
        chk("held_sready", 512'(a_sr), 512'(1'b0));
        areset = 1'b1;
        #1;
        chk("midrst_mvalid", 512'(a_mv), 512'(1'b0));
        chk("midrst_b_cnt", 512'(b_cnt), 512'(0));
        @(posedge aclk);
        #1;
        areset = 1'b0;
        a_force = 1'b1;
        t0 = a_ntid;
        @(posedge aclk);
        #1;
        send(0, 512'(64'h5555_5555_A055_5555), 64'hFF, 4'd6, 1'b0, 1'b1, 512'(64'h5555_5555_A055_5555));
        send(0, 512'(64'h0000_0000_A000_0000), 64'hFF, 4'd6, 1'b1, 1'b1, 512'(64'h0000_0000_A600_0000));
        drain(0);
        chk("postrst_tid_err", 512'(a_ntid - t0), 512'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
